// File: rtl/spmdv_stream_engine.sv
// spmdv_stream_engine
//   Sparse-matrix x dense-vector engine. A single byte stream loads a
//   fixed-NNZ-per-row weight matrix (values, then column indices), a bias
//   vector and NUM_VEC dense vectors. The engine then produces
//   y = W*x + (bias << BIAS_SHIFT) for each vector, one non-zero per cycle,
//   through a 3-stage pipeline into a one-entry output register.
//   A vector-only reload reuses the weights kept from the last full load.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   start, start_mode            run request (IDLE only); 0 = full, 1 = vectors only
//   in_data, in_valid, in_ready  load stream (transfer on in_valid & in_ready)
//   o_result, o_valid, o_ready   row results (transfer on o_valid & o_ready)
//   o_last                       marks the final result of the run
//   busy                         high in every state except IDLE
//   done                         one-cycle pulse after the last result transfers
module spmdv_stream_engine #(
    parameter int ROWS       = 256,
    parameter int NNZ        = 48,
    parameter int VEC_LEN    = 256,
    parameter int NUM_VEC    = 16,
    parameter int DW         = 8,
    parameter int ACC_W      = 22,
    parameter int BIAS_SHIFT = 4,
    parameter int SATURATE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_mode,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] o_result,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_last,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(VEC_LEN);
    localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int NW = ROWS * NNZ;
    localparam int WA = $clog2(NW);
    localparam int RW = $clog2(ROWS);
    localparam int KW = $clog2(NNZ);
    localparam int LW = (WA > CW) ? WA : CW;

    typedef enum logic [2:0] {
        S_IDLE, S_LD_VAL, S_LD_POS, S_LD_BIAS, S_LD_VEC, S_CAL, S_DONE
    } state_t;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        // Once a carry escapes, every later add of the row also carries or
        // adds zero, so pinning here keeps the row at all-ones.
        if (SATURATE != 0 && s[ACC_W]) return '1;
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] widen_prod(input logic [DW-1:0] a,
                                                    input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        p = (2*DW)'(a) * (2*DW)'(b);
        return ACC_W'(p);
    endfunction

    function automatic logic [ACC_W-1:0] bias_ext(input logic [DW-1:0] b);
        logic [ACC_W-1:0] t;
        t = ACC_W'(b);
        return t << BIAS_SHIFT;
    endfunction

    logic [DW-1:0] wval_mem [NW];
    logic [CW-1:0] wpos_mem [NW];
    logic [DW-1:0] bias_mem [ROWS];
    logic [DW-1:0] vec_mem  [2**(VW+CW)];

    state_t            state_q, state_d;
    logic [LW-1:0]     ld_cnt_q;
    logic [VW-1:0]     ld_v_q;
    logic              wl_q;
    logic [WA-1:0]     wi_q;
    logic [KW-1:0]     k_q;
    logic [RW-1:0]     r_q;
    logic [VW-1:0]     cv_q;
    logic              iss_done_q;
    logic              vld_p1_q, last_p1_q, fin_p1_q;
    logic              vld_p2_q, last_p2_q, fin_p2_q;
    logic [DW-1:0]     w_p1_q, w_p2_q, x_p2_q;
    logic [CW-1:0]     idx_p1_q;
    logic [RW-1:0]     row_p1_q, row_p2_q;
    logic [VW-1:0]     vec_p1_q;
    logic [ACC_W-1:0]  acc_q, acc_sum, row_total;
    logic              o_valid_q, o_last_q;
    logic [ACC_W-1:0]  o_result_q;
    logic              xfer_in, xfer_out, stall, issue, ld_last;

    assign in_ready = (state_q == S_LD_VAL) || (state_q == S_LD_POS) ||
                      (state_q == S_LD_BIAS) || (state_q == S_LD_VEC);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign o_valid  = o_valid_q;
    assign o_result = o_result_q;
    assign o_last   = o_last_q;

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = o_valid_q && o_ready;
    // A row total with nowhere to go freezes S0..S2 together.
    assign stall    = vld_p2_q && last_p2_q && o_valid_q && !o_ready;
    assign issue    = (state_q == S_CAL) && !iss_done_q && !stall;

    always_comb begin
        ld_last = 1'b0;
        case (state_q)
            S_LD_VAL, S_LD_POS: ld_last = (ld_cnt_q == LW'(NW - 1));
            S_LD_BIAS:          ld_last = (ld_cnt_q == LW'(ROWS - 1));
            S_LD_VEC:           ld_last = (ld_cnt_q == LW'(VEC_LEN - 1)) &&
                                          (ld_v_q == VW'(NUM_VEC - 1));
            default:            ld_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (start_mode && wl_q) ? S_LD_VEC : S_LD_VAL;
            S_LD_VAL:  if (xfer_in && ld_last) state_d = S_LD_POS;
            S_LD_POS:  if (xfer_in && ld_last) state_d = S_LD_BIAS;
            S_LD_BIAS: if (xfer_in && ld_last) state_d = S_LD_VEC;
            S_LD_VEC:  if (xfer_in && ld_last) state_d = S_CAL;
            S_CAL:     if (xfer_out && o_last_q) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt_q <= '0;
            ld_v_q   <= '0;
            wl_q     <= 1'b0;
        end else begin
            if (state_q != state_d) begin
                ld_cnt_q <= '0;
                ld_v_q   <= '0;
            end else if (xfer_in) begin
                if (state_q == S_LD_VEC && ld_cnt_q == LW'(VEC_LEN - 1)) begin
                    ld_cnt_q <= '0;
                    ld_v_q   <= ld_v_q + 1'b1;
                end else begin
                    ld_cnt_q <= ld_cnt_q + 1'b1;
                end
            end
            if (state_q == S_LD_BIAS && state_d == S_LD_VEC) wl_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer_in) begin
            case (state_q)
                S_LD_VAL:  wval_mem[ld_cnt_q[WA-1:0]] <= in_data;
                S_LD_POS:  wpos_mem[ld_cnt_q[WA-1:0]] <= in_data[CW-1:0];
                S_LD_BIAS: bias_mem[ld_cnt_q[RW-1:0]] <= in_data;
                S_LD_VEC:  vec_mem[{ld_v_q, ld_cnt_q[CW-1:0]}] <= in_data;
                default:   ;
            endcase
        end
    end

    // S0: walk k within row r within vector v, reading weight/index memories
    always_ff @(posedge clk) begin
        if (rst || state_q != S_CAL) begin
            wi_q       <= '0;
            k_q        <= '0;
            r_q        <= '0;
            cv_q       <= '0;
            iss_done_q <= 1'b0;
        end else if (issue) begin
            wi_q <= (wi_q == WA'(NW - 1)) ? '0 : wi_q + 1'b1;
            if (k_q == KW'(NNZ - 1)) begin
                k_q <= '0;
                if (r_q == RW'(ROWS - 1)) begin
                    r_q <= '0;
                    if (cv_q == VW'(NUM_VEC - 1)) iss_done_q <= 1'b1;
                    else                          cv_q <= cv_q + 1'b1;
                end else begin
                    r_q <= r_q + 1'b1;
                end
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else if (!stall) begin
            vld_p1_q <= issue;
            vld_p2_q <= vld_p1_q;
        end
    end

    // S1: vector memory read at {v, idx}; S2 operands registered
    always_ff @(posedge clk) begin
        if (!stall) begin
            w_p1_q    <= wval_mem[wi_q];
            idx_p1_q  <= wpos_mem[wi_q];
            row_p1_q  <= r_q;
            vec_p1_q  <= cv_q;
            last_p1_q <= (k_q == KW'(NNZ - 1));
            fin_p1_q  <= (k_q == KW'(NNZ - 1)) && (r_q == RW'(ROWS - 1)) &&
                         (cv_q == VW'(NUM_VEC - 1));
            w_p2_q    <= w_p1_q;
            x_p2_q    <= vec_mem[{vec_p1_q, idx_p1_q}];
            row_p2_q  <= row_p1_q;
            last_p2_q <= last_p1_q;
            fin_p2_q  <= fin_p1_q;
        end
    end

    // S2: accumulate; the last non-zero of a row adds the shifted bias
    assign acc_sum   = sat_add(acc_q, widen_prod(w_p2_q, x_p2_q));
    assign row_total = sat_add(acc_sum, bias_ext(bias_mem[row_p2_q]));

    always_ff @(posedge clk) begin
        if (state_q != S_CAL)          acc_q <= '0;
        else if (vld_p2_q && !stall)   acc_q <= last_p2_q ? '0 : acc_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q  <= 1'b0;
            o_result_q <= '0;
            o_last_q   <= 1'b0;
        end else if (vld_p2_q && last_p2_q && !stall) begin
            o_valid_q  <= 1'b1;
            o_result_q <= row_total;
            o_last_q   <= fin_p2_q;
        end else if (xfer_out) begin
            o_valid_q  <= 1'b0;
            o_last_q   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spmdv_stream_engine.sv
module tb_spmdv_stream_engine;
    logic        clk = 1'b0;
    logic        rst, start, start_mode, in_valid, o_ready;
    logic [7:0]  in_data;
    logic        in_ready_a, o_valid_a, o_last_a, busy_a, done_a;
    logic        in_ready_b, o_valid_b, o_last_b, busy_b, done_b;
    logic [16:0] o_result_a, o_result_b;

    always #5 clk = ~clk;

    // a: wrapping arithmetic, b: saturating; both see identical stimulus
    spmdv_stream_engine #(.ROWS(4), .NNZ(2), .VEC_LEN(8), .NUM_VEC(2), .DW(8),
                          .ACC_W(17), .BIAS_SHIFT(4), .SATURATE(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .start_mode(start_mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .o_result(o_result_a), .o_valid(o_valid_a), .o_ready(o_ready),
        .o_last(o_last_a), .busy(busy_a), .done(done_a));

    spmdv_stream_engine #(.ROWS(4), .NNZ(2), .VEC_LEN(8), .NUM_VEC(2), .DW(8),
                          .ACC_W(17), .BIAS_SHIFT(4), .SATURATE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .start_mode(start_mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .o_result(o_result_b), .o_valid(o_valid_b), .o_ready(o_ready),
        .o_last(o_last_b), .busy(busy_b), .done(done_b));

    int checks = 0;
    int errors = 0;

    // reference contents of the engine's memories
    logic [7:0]  W [8];
    logic [2:0]  P [8];
    logic [7:0]  B [4];
    logic [7:0]  X [16];
    logic [16:0] ea [8];
    logic [16:0] eb [8];
    bit          wl = 1'b0;

    typedef struct {
        logic [7:0]        w;
        logic [7:0]        b;
        bit                ramp;
        logic [7:0]        vc;
        int                gap;
        int                rdy;
        logic [7:0][16:0]  exp_wrap;
        logic [7:0][16:0]  exp_sat;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [16:0] model(input int v, input int r, input bit sat);
        longint s;
        s = longint'(B[r]) * 16;
        for (int k = 0; k < 2; k++)
            s += longint'(W[r*2+k]) * longint'(X[v*8 + int'(P[r*2+k])]);
        if (sat && s > 131071) return 17'h1FFFF;
        return 17'(s % 131072);
    endfunction

    task automatic fill_model();
        for (int n = 0; n < 8; n++) begin
            ea[n] = model(n / 4, n % 4, 1'b0);
            eb[n] = model(n / 4, n % 4, 1'b1);
        end
    endtask

    task automatic randomize_weights();
        for (int i = 0; i < 8; i++) begin
            W[i] = 8'($urandom);
            P[i] = 3'($urandom);
        end
        for (int i = 0; i < 4; i++) B[i] = 8'($urandom);
    endtask

    task automatic send_beat(input logic [7:0] d);
        int t;
        t = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready_a && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout waited=%0d limit=50", t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // rdy: 0 = always ready (timing checked), 1 = random, 2 = 20-cycle hold at row 1
    task automatic run(input bit mode, input int gap, input int rdy, input int abort_at);
        bit         full;
        logic [7:0] q[$];
        int         n, cyc, prev, hold;
        bit         held;
        full = !(mode && wl);
        start = 1'b1;
        start_mode = mode;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy_a), 32'd1);
        chk("in_ready_after_start", 32'(in_ready_a), 32'd1);
        if (full) begin
            for (int i = 0; i < 8; i++) q.push_back(W[i]);
            for (int i = 0; i < 8; i++) q.push_back({5'($urandom), P[i]});
            for (int i = 0; i < 4; i++) q.push_back(B[i]);
        end
        for (int i = 0; i < 16; i++) q.push_back(X[i]);
        for (int i = 0; i < q.size(); i++) begin
            send_beat(q[i]);
            if (i != q.size() - 1) begin
                if ((gap > 0 && i % gap == gap - 1) || (gap < 0 && $urandom_range(0, 3) == 0)) begin
                    @(posedge clk); #1;
                end
            end
        end
        if (full) wl = 1'b1;
        chk("in_ready_cal", 32'(in_ready_a), 32'd0);
        chk("busy_cal", 32'(busy_a), 32'd1);
        n = 0; cyc = 0; prev = 0; hold = 0; held = 1'b0;
        while (n < 8 && cyc < 500) begin
            if (abort_at >= 0 && n == abort_at) begin
                start = 1'b0;
                o_ready = 1'b1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("abort_in_ready", 32'(in_ready_a), 32'd0);
                chk("abort_o_valid", 32'(o_valid_a), 32'd0);
                chk("abort_o_result", 32'(o_result_a), 32'd0);
                chk("abort_o_result_b", 32'(o_result_b), 32'd0);
                chk("abort_o_last", 32'(o_last_a), 32'd0);
                chk("abort_busy", 32'(busy_a), 32'd0);
                chk("abort_done", 32'(done_a), 32'd0);
                wl = 1'b0;
                return;
            end
            start = (cyc == 1);
            if (rdy == 2 && !held && o_valid_a && n == 1) begin
                held = 1'b1;
                hold = 20;
            end
            if (hold > 0) begin
                o_ready = 1'b0;
                hold--;
            end else if (rdy == 1) o_ready = ($urandom_range(0, 3) != 0);
            else                   o_ready = 1'b1;
            if (o_valid_a) begin
                if (o_ready) begin
                    chk("result_wrap", 32'(o_result_a), 32'(ea[n]));
                    chk("result_sat", 32'(o_result_b), 32'(eb[n]));
                    chk("valid_b", 32'(o_valid_b), 32'd1);
                    chk("last_a", 32'(o_last_a), 32'(n == 7));
                    chk("last_b", 32'(o_last_b), 32'(n == 7));
                    if (rdy == 0) begin
                        if (n == 0) chk("first_latency", 32'(cyc), 32'd4);
                        else        chk("spacing", 32'(cyc - prev), 32'd2);
                    end
                    prev = cyc;
                    n++;
                end else begin
                    chk("held_result", 32'(o_result_a), 32'(ea[n]));
                    chk("held_last", 32'(o_last_a), 32'(n == 7));
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        o_ready = 1'b1;
        if (n < 8) begin
            checks++;
            errors++;
            $display("FAIL result_timeout got=%0d want=8", n);
            return;
        end
        chk("done_pulse", 32'(done_a), 32'd1);
        chk("done_pulse_b", 32'(done_b), 32'd1);
        chk("busy_in_done", 32'(busy_a), 32'd1);
        @(posedge clk); #1;
        chk("done_clear", 32'(done_a), 32'd0);
        chk("busy_idle", 32'(busy_a), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time_limit_reached");
        $fatal(1);
    end

    initial begin
        int mode;
        // fields: w, b, ramp, const, gap, rdy, results (last first), saturating results
        tbl[0] = '{8'd1, 8'd1, 1'b1, 8'd0, 3, 0,
                   {17'd42, 17'd40, 17'd38, 17'd36, 17'd26, 17'd24, 17'd22, 17'd20},
                   {17'd42, 17'd40, 17'd38, 17'd36, 17'd26, 17'd24, 17'd22, 17'd20}};
        tbl[1] = '{8'd255, 8'd255, 1'b0, 8'd255, 0, 0,
                   {8{17'd3058}}, {8{17'd131071}}};
        tbl[2] = '{8'd2, 8'd0, 1'b1, 8'd0, 0, 1,
                   {17'd52, 17'd48, 17'd44, 17'd40, 17'd20, 17'd16, 17'd12, 17'd8},
                   {17'd52, 17'd48, 17'd44, 17'd40, 17'd20, 17'd16, 17'd12, 17'd8}};
        tbl[3] = '{8'd3, 8'd16, 1'b0, 8'd10, 0, 0,
                   {8{17'd316}}, {8{17'd316}}};
        tbl[4] = '{8'd1, 8'd1, 1'b1, 8'd0, 0, 2,
                   {17'd42, 17'd40, 17'd38, 17'd36, 17'd26, 17'd24, 17'd22, 17'd20},
                   {17'd42, 17'd40, 17'd38, 17'd36, 17'd26, 17'd24, 17'd22, 17'd20}};

        rst = 1'b1; start = 1'b0; start_mode = 1'b0;
        in_valid = 1'b0; in_data = 8'd0; o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready_a), 32'd0);
        chk("reset_o_valid", 32'(o_valid_a), 32'd0);
        chk("reset_o_valid_b", 32'(o_valid_b), 32'd0);
        chk("reset_o_result", 32'(o_result_a), 32'd0);
        chk("reset_o_result_b", 32'(o_result_b), 32'd0);
        chk("reset_o_last", 32'(o_last_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_done", 32'(done_a), 32'd0);

        for (int t = 0; t < 5; t++) begin
            for (int r = 0; r < 4; r++) begin
                P[2*r]   = 3'(r);
                P[2*r+1] = 3'(r + 4);
                B[r]     = tbl[t].b;
            end
            for (int i = 0; i < 8; i++) W[i] = tbl[t].w;
            for (int i = 0; i < 16; i++) X[i] = tbl[t].ramp ? 8'(i) : tbl[t].vc;
            for (int i = 0; i < 8; i++) begin
                ea[i] = tbl[t].exp_wrap[i];
                eb[i] = tbl[t].exp_sat[i];
            end
            run(1'b0, tbl[t].gap, tbl[t].rdy, -1);
        end

        // vector-only reload keeps the last weights
        for (int i = 0; i < 16; i++) X[i] = 8'($urandom);
        fill_model();
        run(1'b1, 0, 0, -1);

        // reset during row 2, then start_mode=1 must act as a full load
        randomize_weights();
        for (int i = 0; i < 16; i++) X[i] = 8'($urandom);
        fill_model();
        run(1'b0, 0, 0, 2);
        randomize_weights();
        for (int i = 0; i < 16; i++) X[i] = 8'($urandom);
        fill_model();
        run(1'b1, 0, 0, -1);

        for (int it = 0; it < 8; it++) begin
            mode = int'($urandom_range(0, 1));
            if (!(mode == 1 && wl)) randomize_weights();
            for (int i = 0; i < 16; i++) X[i] = 8'($urandom);
            fill_model();
            run(mode[0], -1, 1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spmdv_stream_engine.md
# spmdv_stream_engine

Parametrised sparse-matrix × dense-vector engine: the next-generation SpMDV block, with matrix shape, widths and vector count set by parameters. It loads a fixed-NNZ-per-row sparse weight matrix, a bias vector and NUM_VEC dense vectors over a single valid/ready byte stream, then computes y = W·x + (bias << BIAS_SHIFT) for each vector. Results leave on a valid/ready output port with backpressure. It adds a vector-only reload mode, so new vectors can be processed without re-sending the weights.

## Interface
- ROWS, 256, matrix rows (≥2)
- NNZ, 48, non-zeros per row (≥2)
- VEC_LEN, 256, vector length; column index width CW = clog2(VEC_LEN)
- NUM_VEC, 16, vectors per run (≥1)
- DW, 8, weight/bias/vector element width (unsigned)
- ACC_W, 22, accumulator/result width (≥ 2*DW + clog2(NNZ))
- BIAS_SHIFT, 4, left shift applied to bias before the add
- SATURATE, 0, 0 = wrap modulo 2^ACC_W, 1 = clamp at 2^ACC_W−1
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle run request; accepted only in IDLE
- start_mode  in  1  sampled with start: 0 = full load, 1 = vector-only reload
- in_data  in  DW  load stream beat
- in_valid  in  1  in_data valid
- in_ready  out  1  engine accepts a beat; a beat transfers when in_valid & in_ready
- o_result  out  ACC_W  row result
- o_valid  out  1  o_result valid
- o_ready  in  1  sink accepts; a result transfers when o_valid & o_ready
- o_last  out  1  qualifies the final result of the run (row ROWS−1, vector NUM_VEC−1)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result transfers

## Operation
- States: IDLE, LD_VAL, LD_POS, LD_BIAS, LD_VEC, CAL, DONE.
- IDLE:
  - start with start_mode=0 → LD_VAL.
  - start with start_mode=1 → LD_VEC, but only if `weights_loaded` is set; otherwise the run is treated as a full load.
- Load order, one element per transferred beat:
  - LD_VAL: ROWS·NNZ weight values, row-major.
  - LD_POS: ROWS·NNZ column indices, low CW bits used.
  - LD_BIAS: ROWS biases.
  - LD_VEC: NUM_VEC·VEC_LEN entries, vector-major.
- Each load state advances on the transfer of its final element. LD_BIAS exit sets `weights_loaded`. in_ready=1 only in LD_* states.
- CAL processes one non-zero per cycle in a 3-stage pipeline:
  - S0: read weight and index memories at k.
  - S1: read the vector memory at {v, idx}.
  - S2: acc += w·x.
- At the last non-zero of a row, S2 adds (bias[r] << BIAS_SHIFT) and writes the total into the 1-entry output register. The accumulator clears for the next row in the same cycle.
- Output order: vector 0 rows 0..ROWS−1, then vector 1, and so on.
- Backpressure: if a row total is ready while the output register is still full and not transferring this cycle, the whole pipeline freezes (S0–S2 hold) until the transfer.
- After the last result transfers → DONE (done=1 for one cycle) → IDLE.
- Arithmetic is unsigned throughout.
  - Products are 2·DW bits, zero-extended to ACC_W.
  - SATURATE=1: any carry out of ACC_W pins the accumulator at all-ones for the rest of the row.
  - SATURATE=0: results wrap modulo 2^ACC_W.
- start is ignored while busy. in_valid outside LD_* is ignored.
- Index values ≥ VEC_LEN (non-power-of-2 VEC_LEN) read an undefined entry; no error is flagged.

## Timing
- Reset: in_ready=0, o_valid=0, o_result=0, o_last=0, busy=0, done=0, state=IDLE, weights_loaded=0. Memory contents are not cleared.
- rst mid-run aborts immediately to IDLE and clears weights_loaded, so the next start must be a full load.
- start at edge t → busy=1 and in_ready=1 from t+1.
- in_ready drops in the cycle after the last LD_VEC transfer. CAL starts that cycle.
- With CAL entry at cycle c and o_ready held high:
  - row 0 result has o_valid=1 at c+NNZ+2;
  - each later result follows exactly NNZ cycles after the previous one.
- o_result and o_last stay stable while o_valid=1 and o_ready=0.
- done asserts the cycle after the o_last transfer. busy falls the cycle after that.

## Test plan
- Full run, ROWS=4, NNZ=2, VEC_LEN=8, NUM_VEC=2, BIAS_SHIFT=4:
  - stimulus: all weights 1, row r indices {r, r+4}, bias 1, vector v entry j = v·8+j;
  - expected vector 0 results: 4+16=20, 6+16=22, 8+16=24, 10+16=26;
  - expected vector 1 results: 36, 38, 40, 42;
  - o_last on the 8th result; done one cycle later.
- Throughput: o_ready=1 and in_valid gaps of 1 cycle every 3 beats → loads complete correctly; result spacing is exactly NNZ after the first.
- Backpressure: hold o_ready=0 for 20 cycles at row 1 → o_result=22 held stable; no result lost or duplicated; the sequence resumes unchanged.
- Saturation: ACC_W=17, SATURATE=1, all weights/vector entries/biases 255, NNZ=2 → every result 131071; SATURATE=0 → (2·65025+4080) mod 2^17 = 3058.
- Vector-only reload: after a full run, start with start_mode=1 and send 16 new entries only → results use the retained weights. start_mode=1 right after reset → behaves as a full load.
- Reset mid-CAL: assert rst during row 2 → next cycle all outputs are 0 and state is IDLE; a subsequent full run gives correct results.
